// File: rtl/qeciphy_fault_reporter_if.sv
// Report channel carrying the captured fault record from the reporter to host/CSR logic.
// The master presents the record; the slave accepts it with report_ready_i.
interface qeciphy_fault_reporter_if #(
  parameter int TS_W = 32
);
  logic            report_valid_o;
  logic            report_ready_i;
  logic [3:0]      report_ecode_o;
  logic [TS_W-1:0] report_ts_o;

  modport master (
    output report_valid_o,
    output report_ecode_o,
    output report_ts_o,
    input  report_ready_i
  );

  modport slave (
    input  report_valid_o,
    input  report_ecode_o,
    input  report_ts_o,
    output report_ready_i
  );
endinterface

// File: rtl/qeciphy_fault_reporter.sv
// Captures the first fatal fault with a timestamp, raises a level interrupt and
// presents the record once over the report channel; flags a stalled channel.
module qeciphy_fault_reporter #(
  parameter int TS_W           = 32,
  parameter int REPORT_TIMEOUT = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            fault_fatal_i,
  input  logic [3:0]                      ecode_i,
  qeciphy_fault_reporter_if.master        report,
  output logic                            irq_o,
  input  logic                            irq_ack_i,
  output logic                            report_stall_o,
  output logic                            busy_o
);

  typedef enum logic [1:0] {IDLE, REPORT, WAIT_ACK, DONE} state_e;

  localparam int                STALL_W   = $clog2(REPORT_TIMEOUT + 1);
  localparam logic [TS_W-1:0]   TS_MAX    = '1;
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(REPORT_TIMEOUT);

  state_e               r_state;
  state_e               w_next;
  logic [TS_W-1:0]      r_ts_cnt;
  logic [TS_W-1:0]      r_ts;
  logic [3:0]           r_ecode;
  logic                 r_irq;
  logic                 r_stall;
  logic [STALL_W-1:0]   r_stall_cnt;
  logic                 w_capture;
  logic                 w_ack_live;
  logic                 w_stalled;

  assign w_capture  = (r_state == IDLE) && fault_fatal_i;
  assign w_ack_live = irq_ack_i && ((r_state == REPORT) || (r_state == WAIT_ACK));
  assign w_stalled  = (r_state == REPORT) && !report.report_ready_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: default assignment first so no path leaves w_next unassigned and infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (fault_fatal_i) w_next = REPORT;
      REPORT:   if (report.report_ready_i) w_next = (r_irq && !irq_ack_i) ? WAIT_ACK : DONE;
      WAIT_ACK: if (irq_ack_i) w_next = DONE;
      DONE:     w_next = DONE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    report.report_valid_o = (r_state == REPORT);
    report.report_ecode_o = r_ecode;
    report.report_ts_o    = r_ts;
    irq_o                 = r_irq;
    report_stall_o        = r_stall;
    busy_o                = (r_state == REPORT) || (r_state == WAIT_ACK);
  end

  // Free-running timestamp that holds at all ones rather than wrapping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ts_cnt <= '0;
    end else if (r_ts_cnt != TS_MAX) begin
      r_ts_cnt <= r_ts_cnt + TS_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ecode <= '0;
      r_ts    <= '0;
      r_irq   <= 1'b0;
    end else if (w_capture) begin
      r_ecode <= ecode_i;
      r_ts    <= r_ts_cnt;
      r_irq   <= 1'b1;
    end else if (w_ack_live) begin
      r_irq   <= 1'b0;
    end
  end

  // Stall timer saturates at the timeout; the flag stays set until reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stall_cnt <= '0;
      r_stall     <= 1'b0;
    end else if (w_stalled && (r_stall_cnt != STALL_MAX)) begin
      r_stall_cnt <= r_stall_cnt + STALL_W'(1);
      if (r_stall_cnt == STALL_MAX - STALL_W'(1)) r_stall <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qeciphy_fault_reporter.sv
// Scoreboard bench: expected records are queued when a fault is driven and
// compared when the report channel handshakes; flag behaviour is checked inline.
module tb_qeciphy_fault_reporter;

  typedef struct {
    logic [3:0]  ecode;
    logic [31:0] ts;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fault = 1'b0, ack = 1'b0;
  logic [3:0]  ecode = '0;
  logic        irq, stall, busy;
  logic        fault_s = 1'b0, ack_s = 1'b0;
  logic [3:0]  ecode_s = '0;
  logic        irq_s, stall_s, busy_s;
  logic [31:0] tb_cyc;
  rec_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;

  qeciphy_fault_reporter_if #(.TS_W(32)) rpt ();
  qeciphy_fault_reporter_if #(.TS_W(4))  rpt_s ();

  qeciphy_fault_reporter #(.TS_W(32), .REPORT_TIMEOUT(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .fault_fatal_i(fault), .ecode_i(ecode),
    .report(rpt.master), .irq_o(irq), .irq_ack_i(ack),
    .report_stall_o(stall), .busy_o(busy)
  );

  qeciphy_fault_reporter #(.TS_W(4), .REPORT_TIMEOUT(1024)) dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .fault_fatal_i(fault_s), .ecode_i(ecode_s),
    .report(rpt_s.master), .irq_o(irq_s), .irq_ack_i(ack_s),
    .report_stall_o(stall_s), .busy_o(busy_s)
  );

  always #5 clk = ~clk;

  // Reference cycle count: equals the timestamp a capture at the next edge should record.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  // Scoreboard monitor, sampling a few ns before the rising edge that would accept.
  always begin
    @(negedge clk);
    #3;
    if (rst_n && rpt.report_valid_o && rpt.report_ready_i) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: got ecode=%h ts=%0d, required no record", rpt.report_ecode_o, rpt.report_ts_o);
      end else begin
        rec_t e;
        e = sb.pop_front();
        if (rpt.report_ecode_o !== e.ecode || rpt.report_ts_o !== e.ts)
          $display("FAIL sb_record: got ecode=%h ts=%0d, required ecode=%h ts=%0d",
                   rpt.report_ecode_o, rpt.report_ts_o, e.ecode, e.ts);
        else n_pass++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    fault = 1'b0; ack = 1'b0; ecode = '0; rpt.report_ready_i = 1'b0;
    fault_s = 1'b0; ack_s = 1'b0; ecode_s = '0; rpt_s.report_ready_i = 1'b0;
    sb.delete();
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic drive_fault(input logic [3:0] code);
    fault = 1'b1;
    ecode = code;
    sb.push_back('{code, tb_cyc});
  endtask

  task automatic test_reset();
    rpt.report_ready_i = 1'b0;
    rpt_s.report_ready_i = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({rpt.report_valid_o, irq, busy, stall, rpt.report_ecode_o, rpt.report_ts_o} !== 40'd0)
      $display("FAIL reset_outputs: got v=%b irq=%b busy=%b stall=%b ecode=%h ts=%h, required all 0",
               rpt.report_valid_o, irq, busy, stall, rpt.report_ecode_o, rpt.report_ts_o);
    else n_pass++;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    rpt.report_ready_i = 1'b1;
    step(100);
    drive_fault(4'h3);
    step(1);
    n_total++;
    if ({rpt.report_valid_o, irq, busy, stall} !== 4'b1110 || rpt.report_ts_o !== 32'd100 || rpt.report_ecode_o !== 4'h3)
      $display("FAIL basic_capture: got vibs=%b ts=%0d ecode=%h, required 1110 ts=100 ecode=3",
               {rpt.report_valid_o, irq, busy, stall}, rpt.report_ts_o, rpt.report_ecode_o);
    else n_pass++;
    step(1);
    n_total++;
    if ({rpt.report_valid_o, irq, busy} !== 3'b011)
      $display("FAIL basic_wait_ack: got vib=%b, required 011", {rpt.report_valid_o, irq, busy});
    else n_pass++;
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    n_total++;
    if ({rpt.report_valid_o, irq, busy} !== 3'b000)
      $display("FAIL basic_done: got vib=%b, required 000", {rpt.report_valid_o, irq, busy});
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    do_reset();
    step(20);
    drive_fault(4'h5);
    step(1);
    for (int i = 0; i < 11; i++) begin
      if (rpt.report_valid_o !== 1'b1 || rpt.report_ecode_o !== 4'h5 || rpt.report_ts_o !== 32'd20) bad++;
      if (i == 10) rpt.report_ready_i = 1'b1;
      step(1);
    end
    rpt.report_ready_i = 1'b0;
    n_total++;
    if (bad != 0) $display("FAIL bp_stable: got %0d unstable valid cycles, required 0", bad);
    else n_pass++;
    n_total++;
    if ({rpt.report_valid_o, irq, busy, stall} !== 4'b0111)
      $display("FAIL bp_accepted: got vibs=%b, required 0111", {rpt.report_valid_o, irq, busy, stall});
    else n_pass++;
    while (tb_cyc < 32'd40) step(1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    n_total++;
    if ({irq, busy} !== 2'b00)
      $display("FAIL bp_ack_done: got irq=%b busy=%b, required 0 0", irq, busy);
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    step(5);
    drive_fault(4'hA);
    step(1);
    step(7);
    n_total++;
    if (stall !== 1'b0 || rpt.report_valid_o !== 1'b1)
      $display("FAIL to_before: got stall=%b valid=%b after 7 stalled cycles, required 0 1", stall, rpt.report_valid_o);
    else n_pass++;
    step(1);
    n_total++;
    if (stall !== 1'b1 || rpt.report_valid_o !== 1'b1)
      $display("FAIL to_reached: got stall=%b valid=%b after 8 stalled cycles, required 1 1", stall, rpt.report_valid_o);
    else n_pass++;
    step(3);
    rpt.report_ready_i = 1'b1;
    step(1);
    rpt.report_ready_i = 1'b0;
    n_total++;
    if (stall !== 1'b1 || rpt.report_valid_o !== 1'b0)
      $display("FAIL to_sticky: got stall=%b valid=%b after accept, required 1 0", stall, rpt.report_valid_o);
    else n_pass++;
  endtask

  task automatic test_ack_ready_same();
    do_reset();
    step(3);
    drive_fault(4'h6);
    step(1);
    rpt.report_ready_i = 1'b1;
    ack = 1'b1;
    step(1);
    rpt.report_ready_i = 1'b0;
    ack = 1'b0;
    n_total++;
    if ({rpt.report_valid_o, irq, busy} !== 3'b000)
      $display("FAIL same_edge: got vib=%b, required 000", {rpt.report_valid_o, irq, busy});
    else n_pass++;
    ecode = 4'h9;
    step(3);
    n_total++;
    if (rpt.report_ecode_o !== 4'h6 || rpt.report_ts_o !== 32'd3 || rpt.report_valid_o !== 1'b0)
      $display("FAIL same_hold: got ecode=%h ts=%0d valid=%b, required 6 3 0",
               rpt.report_ecode_o, rpt.report_ts_o, rpt.report_valid_o);
    else n_pass++;
  endtask

  task automatic test_early_ack();
    do_reset();
    ack = 1'b1;
    step(3);
    ack = 1'b0;
    drive_fault(4'hC);
    step(1);
    n_total++;
    if ({rpt.report_valid_o, irq, busy} !== 3'b111)
      $display("FAIL early_ack_forgotten: got vib=%b, required 111", {rpt.report_valid_o, irq, busy});
    else n_pass++;
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    fault = 1'b0;
    n_total++;
    if ({rpt.report_valid_o, irq, busy} !== 3'b101)
      $display("FAIL ack_in_report: got vib=%b, required 101", {rpt.report_valid_o, irq, busy});
    else n_pass++;
    rpt.report_ready_i = 1'b1;
    step(1);
    rpt.report_ready_i = 1'b0;
    n_total++;
    if ({rpt.report_valid_o, irq, busy} !== 3'b000 || rpt.report_ecode_o !== 4'hC)
      $display("FAIL remembered_ack: got vib=%b ecode=%h, required 000 c",
               {rpt.report_valid_o, irq, busy}, rpt.report_ecode_o);
    else n_pass++;
  endtask

  task automatic test_ts_saturation();
    do_reset();
    rpt_s.report_ready_i = 1'b1;
    step(40);
    fault_s = 1'b1;
    ecode_s = 4'h0;
    step(1);
    n_total++;
    if (rpt_s.report_ts_o !== 4'hF || rpt_s.report_ecode_o !== 4'h0 || rpt_s.report_valid_o !== 1'b1 || irq_s !== 1'b1)
      $display("FAIL ts_saturated: got ts=%h ecode=%h valid=%b irq=%b, required f 0 1 1",
               rpt_s.report_ts_o, rpt_s.report_ecode_o, rpt_s.report_valid_o, irq_s);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    step(10);
    drive_fault(4'h7);
    step(3);
    #2 rst_n = 1'b0;
    #1;
    fault = 1'b0;
    sb.delete();
    n_total++;
    if ({rpt.report_valid_o, irq, busy, stall, rpt.report_ecode_o, rpt.report_ts_o} !== 40'd0)
      $display("FAIL async_reset: got v=%b irq=%b busy=%b stall=%b ecode=%h ts=%h, required all 0",
               rpt.report_valid_o, irq, busy, stall, rpt.report_ecode_o, rpt.report_ts_o);
    else n_pass++;
    step(2);
    rst_n = 1'b1;
    rpt.report_ready_i = 1'b1;
    step(6);
    drive_fault(4'h8);
    step(1);
    n_total++;
    if (rpt.report_ts_o !== 32'd6 || rpt.report_ecode_o !== 4'h8 || irq !== 1'b1)
      $display("FAIL fresh_capture: got ts=%0d ecode=%h irq=%b, required 6 8 1",
               rpt.report_ts_o, rpt.report_ecode_o, irq);
    else n_pass++;
    step(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_ack_ready_same();
    test_early_ack();
    test_ts_saturation();
    test_async_reset();
    step(2);
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_drained: got %0d records never reported, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
